// File: rtl/memory_responder.sv
// Word-addressed RAM responder for the multicycle control path: req/ack handshake
// with a fixed wait-state count; out-of-range accesses are flagged, never executed.
module memory_responder #(
   parameter int nBit        = 16,
   parameter int ABits       = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             we,
   input  logic [ABits-1:0] addr,
   input  logic [nBit-1:0]  wdata,
   output logic [nBit-1:0]  rdata,
   output logic             ack,
   output logic             err,
   output logic             busy
);

   // state  | meaning
   // S_IDLE | waiting for req; latches addr/we/wdata on the request edge
   // S_WAIT | counting wait states down from WAIT_CYCLES to 1
   // S_RESP | one-cycle ack strobe; operation already completed on entry
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0]     WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [ABits:0] DEPTH_L   = (ABits+1)'(DEPTH);

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic [ABits-1:0] r_addr;
   logic             r_we;
   logic [nBit-1:0]  r_wdata;
   logic [nBit-1:0]  r_mem [DEPTH];

   logic             w_commit;
   logic [ABits-1:0] w_op_addr;
   logic             w_op_we;
   logic [nBit-1:0]  w_op_wdata;
   logic             w_in_range;

   // With zero wait states the operation commits on the sampling edge, so it
   // must use the live inputs rather than the not-yet-latched copies.
   always_comb begin
      w_op_addr  = r_addr;
      w_op_we    = r_we;
      w_op_wdata = r_wdata;
      w_commit   = 1'b0;
      if (r_state == S_IDLE) begin
         w_op_addr  = addr;
         w_op_we    = we;
         w_op_wdata = wdata;
         w_commit   = req && (WAIT_CYCLES == 0);
      end else if (r_state == S_WAIT) begin
         w_commit   = (r_cnt == 4'd1);
      end
      w_in_range = ({1'b0, w_op_addr} < DEPTH_L);
   end

   // Gating on reset keeps an abandoned write out of RAM if reset is held
   // across what would have been the commit edge.
   always_ff @(posedge clk) begin
      if (reset && w_commit && w_op_we && w_in_range)
         r_mem[w_op_addr] <= w_op_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         rdata   <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               ack  <= 1'b0;
               err  <= 1'b0;
               busy <= 1'b0;
               if (req) begin
                  r_addr  <= addr;
                  r_we    <= we;
                  r_wdata <= wdata;
                  busy    <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= WAIT_INIT;
                  end
               end
            end
            S_WAIT: begin
               busy  <= 1'b1;
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1)
                  r_state <= S_RESP;
            end
            S_RESP: begin
               r_state <= S_IDLE;
               ack     <= 1'b0;
               err     <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               ack     <= 1'b0;
               err     <= 1'b0;
               busy    <= 1'b0;
            end
         endcase

         if (w_commit) begin
            ack <= 1'b1;
            if (!w_in_range) begin
               err   <= 1'b1;
               rdata <= '0;
            end else if (!w_op_we) begin
               rdata <= r_mem[w_op_addr];
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances cover WAIT_CYCLES 2/0/3
// and a reduced DEPTH; expected values are hand-computed constants.
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic        req_v   [3];
   logic [15:0] rdata_v [3];
   logic        ack_v   [3];
   logic        err_v   [3];
   logic        busy_v  [3];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   // instance 0: W=2, DEPTH=200; instance 1: W=0; instance 2: W=3
   memory_responder #(.nBit(16), .ABits(8), .DEPTH(200), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata_v[0]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0]));

   memory_responder #(.nBit(16), .ABits(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata_v[1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1]));

   memory_responder #(.nBit(16), .ABits(8), .DEPTH(256), .WAIT_CYCLES(3)) u_dut_c (
      .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata_v[2]), .ack(ack_v[2]), .err(err_v[2]), .busy(busy_v[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input int s, input string tag);
      chk({tag, "_ack"},  32'(ack_v[s]),  32'd0);
      chk({tag, "_err"},  32'(err_v[s]),  32'd0);
      chk({tag, "_busy"}, 32'(busy_v[s]), 32'd0);
   endtask

   // One transaction on instance s. With mutate set, addr/we/wdata are changed
   // right after the sampling edge to prove only latched values are used.
   task automatic txn(input int s, input logic w, input logic [7:0] a, input logic [15:0] d,
                      input bit mutate, output logic [15:0] rd, output logic e,
                      output int lat, output int bcnt);
      we = w; addr = a; wdata = d; req_v[s] = 1'b1;
      tick();
      req_v[s] = 1'b0;
      if (mutate) begin
         we = ~w; addr = a + 8'd1; wdata = 16'hFFFF;
      end
      lat = 0; bcnt = 0;
      if (busy_v[s]) bcnt++;
      while (!ack_v[s] && lat < 20) begin
         tick();
         lat++;
         if (busy_v[s]) bcnt++;
      end
      rd = rdata_v[s];
      e  = err_v[s];
      if (!ack_v[s]) chk("ack_timeout", 32'd0, 32'd1);
      tick();
      chk_idle(s, "post_resp");
   endtask

   logic [15:0] rd;
   logic        e;
   int          lat, bcnt;

   initial begin
      reset = 1'b0; we = 1'b0; addr = 8'h00; wdata = 16'h0000;
      for (int i = 0; i < 3; i++) req_v[i] = 1'b0;

      // reset held two cycles, then three idle cycles
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         chk_idle(i, "rst");
         chk("rst_rdata", 32'(rdata_v[i]), 32'd0);
      end
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_idle(0, "idle");
         chk("idle_rdata", 32'(rdata_v[0]), 32'd0);
      end

      // W=2 write then read
      txn(0, 1'b1, 8'h10, 16'hBEEF, 1'b0, rd, e, lat, bcnt);
      chk("w10_lat", 32'(lat), 32'd2);
      chk("w10_busy", 32'(bcnt), 32'd3);
      chk("w10_err", 32'(e), 32'd0);
      chk("w10_rdata_hold", 32'(rd), 32'd0);
      txn(0, 1'b0, 8'h10, 16'h0000, 1'b0, rd, e, lat, bcnt);
      chk("r10_data", 32'(rd), 32'hBEEF);
      chk("r10_lat", 32'(lat), 32'd2);

      // back-to-back: req held through write @20, read starts right after RESP
      we = 1'b1; addr = 8'h20; wdata = 16'h1234; req_v[0] = 1'b1;
      tick();
      lat = 0;
      while (!ack_v[0] && lat < 20) begin tick(); lat++; end
      chk("b2b_w_ack", 32'(ack_v[0]), 32'd1);
      chk("b2b_w_err", 32'(err_v[0]), 32'd0);
      we = 1'b0;
      tick();
      chk("b2b_gap_busy", 32'(busy_v[0]), 32'd0);
      chk("b2b_gap_ack", 32'(ack_v[0]), 32'd0);
      tick();
      chk("b2b_r_busy", 32'(busy_v[0]), 32'd1);
      req_v[0] = 1'b0;
      lat = 0;
      while (!ack_v[0] && lat < 20) begin tick(); lat++; end
      chk("b2b_r_lat", 32'(lat), 32'd2);
      chk("b2b_r_data", 32'(rdata_v[0]), 32'h1234);
      tick();

      // out-of-range boundary at DEPTH=200
      txn(0, 1'b1, 8'hC8, 16'hAAAA, 1'b0, rd, e, lat, bcnt);
      chk("wC8_err", 32'(e), 32'd1);
      txn(0, 1'b0, 8'hC8, 16'h0000, 1'b0, rd, e, lat, bcnt);
      chk("rC8_err", 32'(e), 32'd1);
      chk("rC8_data", 32'(rd), 32'd0);
      txn(0, 1'b1, 8'hC7, 16'hAAAA, 1'b0, rd, e, lat, bcnt);
      chk("wC7_err", 32'(e), 32'd0);
      txn(0, 1'b0, 8'hC7, 16'h0000, 1'b0, rd, e, lat, bcnt);
      chk("rC7_err", 32'(e), 32'd0);
      chk("rC7_data", 32'(rd), 32'hAAAA);

      // W=0
      txn(1, 1'b1, 8'h01, 16'h0101, 1'b0, rd, e, lat, bcnt);
      chk("w0_lat", 32'(lat), 32'd0);
      chk("w0_busy", 32'(bcnt), 32'd1);
      txn(1, 1'b0, 8'h01, 16'h0000, 1'b0, rd, e, lat, bcnt);
      chk("r0_lat", 32'(lat), 32'd0);
      chk("r0_data", 32'(rd), 32'h0101);

      // W=3, inputs changed during WAIT must be ignored
      txn(2, 1'b1, 8'h06, 16'h0606, 1'b0, rd, e, lat, bcnt);
      txn(2, 1'b1, 8'h05, 16'h7777, 1'b0, rd, e, lat, bcnt);
      chk("w3_lat", 32'(lat), 32'd3);
      chk("w3_busy", 32'(bcnt), 32'd4);
      txn(2, 1'b0, 8'h05, 16'h0000, 1'b1, rd, e, lat, bcnt);
      chk("w3_latched_data", 32'(rd), 32'h7777);
      txn(2, 1'b0, 8'h06, 16'h0000, 1'b0, rd, e, lat, bcnt);
      chk("w3_no_stray_write", 32'(rd), 32'h0606);

      // reset during WAIT abandons the write
      txn(0, 1'b1, 8'h30, 16'h1111, 1'b0, rd, e, lat, bcnt);
      txn(0, 1'b0, 8'h30, 16'h0000, 1'b0, rd, e, lat, bcnt);
      chk("pre30_data", 32'(rd), 32'h1111);
      we = 1'b1; addr = 8'h30; wdata = 16'h5555; req_v[0] = 1'b1;
      tick();
      req_v[0] = 1'b0;
      tick();
      chk("mid_busy", 32'(busy_v[0]), 32'd1);
      reset = 1'b0;
      #1;
      chk_idle(0, "async_rst");
      chk("async_rst_rdata", 32'(rdata_v[0]), 32'd0);
      tick(); tick();
      reset = 1'b1;
      tick();
      txn(0, 1'b0, 8'h30, 16'h0000, 1'b0, rd, e, lat, bcnt);
      chk("r30_after_rst", 32'(rd), 32'h1111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
